// File: rtl/exe_stage.sv
// ---------------------------------------------------------------------------
// exe_stage
//   Execute stage of the 5-stage ARM-subset pipeline. Builds the second ALU
//   operand (Val2) from the shifter operand, runs the ALU, computes the branch
//   target and owns the NZCV status register read by the ID-stage condition
//   check.
//
//   Build option: define EXE_MUL_EN to include the iterative shift-add
//   multiplier (parameter MUL_CYCLES). While it runs, Stall freezes the front
//   end. Without EXE_MUL_EN, MUL (1111) yields ALU_Res=0, never touches SR,
//   and Stall is tied low.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   EXE_CMD_In [3:0]    ALU operation
//   MEM_R_EN_In         load in EXE (forces ADD, offset form of Val2)
//   MEM_W_EN_In         store in EXE (forces ADD, offset form of Val2)
//   B_In                branch in EXE
//   S_In                update NZCV when the instruction completes
//   PC_In [31:0]        PC+4 of this instruction
//   Val_Rn_In [31:0]    first operand
//   Val_Rm_In [31:0]    second register operand
//   imm_In              immediate form of the shifter operand
//   Shift_operand_In    12-bit ARM shifter operand
//   Signed_imm_24_In    branch offset in words
//   ALU_Res [31:0]      ALU result / memory address
//   Br_Addr [31:0]      branch target
//   Branch_Taken        equals B_In
//   SR [3:0]            registered {N,Z,C,V}
//   Stall               multiplier busy; freezes PC, IF/ID and ID/EX
// ---------------------------------------------------------------------------
module exe_stage
`ifdef EXE_MUL_EN
#(
   parameter int MUL_CYCLES = 32
)
`endif
(
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  EXE_CMD_In,
   input  logic        MEM_R_EN_In,
   input  logic        MEM_W_EN_In,
   input  logic        B_In,
   input  logic        S_In,
   input  logic [31:0] PC_In,
   input  logic [31:0] Val_Rn_In,
   input  logic [31:0] Val_Rm_In,
   input  logic        imm_In,
   input  logic [11:0] Shift_operand_In,
   input  logic [23:0] Signed_imm_24_In,
   output logic [31:0] ALU_Res,
   output logic [31:0] Br_Addr,
   output logic        Branch_Taken,
   output logic [3:0]  SR,
   output logic        Stall
);

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;
   localparam logic [3:0] CMD_MUL = 4'b1111;

   logic        isMem;
   logic [3:0]  effCmd;
   logic        isMul;
   logic [31:0] immBase;
   logic [5:0]  immRot;
   logic [31:0] rotImm;
   logic [4:0]  shAmt;
   logic [31:0] shiftRm;
   logic [31:0] val2;
   logic [31:0] addB;
   logic        addCin;
   logic        isArith;
   logic [32:0] sum33;
   logic        ovf;
   logic [31:0] aluRes;
   logic [3:0]  sr_q;
   logic [3:0]  sr_d;

   assign isMem  = MEM_R_EN_In | MEM_W_EN_In;
   assign effCmd = isMem ? CMD_ADD : EXE_CMD_In;
   assign isMul  = (effCmd == CMD_MUL);

   // Val2 operand. Rotates are built as (x >> n) | (x << (32-n)); a shift by
   // 32 yields zero, so n = 0 passes the value through unchanged.
   assign immBase = {24'b0, Shift_operand_In[7:0]};
   assign immRot  = {1'b0, Shift_operand_In[11:8], 1'b0};
   assign rotImm  = (immBase >> immRot) | (immBase << (6'd32 - immRot));
   assign shAmt   = Shift_operand_In[11:7];

   always_comb begin
      shiftRm = Val_Rm_In;
      case (Shift_operand_In[6:5])
         2'b00:   shiftRm = Val_Rm_In << shAmt;
         2'b01:   shiftRm = Val_Rm_In >> shAmt;
         2'b10:   shiftRm = $signed(Val_Rm_In) >>> shAmt;
         default: shiftRm = (Val_Rm_In >> shAmt) |
                            (Val_Rm_In << (6'd32 - {1'b0, shAmt}));
      endcase
   end

   assign val2 = imm_In ? rotImm :
                 isMem  ? {20'b0, Shift_operand_In} : shiftRm;

   // All four arithmetic ops share one 33-bit adder: subtraction feeds the
   // inverted operand, and the carry-in is 1 (SUB) or the current C flag.
   always_comb begin
      addB    = val2;
      addCin  = 1'b0;
      isArith = 1'b0;
      case (effCmd)
         CMD_ADD: isArith = 1'b1;
         CMD_ADC: begin isArith = 1'b1; addCin = sr_q[1]; end
         CMD_SUB: begin isArith = 1'b1; addB = ~val2; addCin = 1'b1; end
         CMD_SBC: begin isArith = 1'b1; addB = ~val2; addCin = sr_q[1]; end
         default: ;
      endcase
   end

   assign sum33 = {1'b0, Val_Rn_In} + {1'b0, addB} + {32'b0, addCin};
   assign ovf   = (Val_Rn_In[31] == addB[31]) && (sum33[31] != Val_Rn_In[31]);

   always_comb begin
      aluRes = 32'b0;
      case (effCmd)
         CMD_MOV: aluRes = val2;
         CMD_MVN: aluRes = ~val2;
         CMD_ADD, CMD_ADC,
         CMD_SUB, CMD_SBC: aluRes = sum33[31:0];
         CMD_AND: aluRes = Val_Rn_In & val2;
         CMD_ORR: aluRes = Val_Rn_In | val2;
         CMD_EOR: aluRes = Val_Rn_In ^ val2;
         default: aluRes = 32'b0;
      endcase
   end

   assign Br_Addr      = PC_In + {{6{Signed_imm_24_In[23]}}, Signed_imm_24_In, 2'b00};
   assign Branch_Taken = B_In;

`ifdef EXE_MUL_EN
   typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mulState_e;

   localparam int CW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 2);

   mulState_e   state_q;
   logic [CW-1:0] cnt_q;
   logic [31:0] prod_q;
   logic [31:0] mcand_q;
   logic [31:0] mplier_q;

   // Shift-add multiplier. The accept cycle in IDLE already folds multiplier
   // bit 0, so cnt_q holds the index of the last bit folded. BUSY folds bit
   // cnt_q+1 and leaves once bit MUL_CYCLES-1 is in, giving MUL_CYCLES stall
   // cycles followed by one DONE cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= MUL_IDLE;
         cnt_q    <= '0;
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         case (state_q)
            MUL_IDLE: begin
               if (isMul) begin
                  prod_q   <= val2[0] ? Val_Rn_In : 32'b0;
                  mcand_q  <= Val_Rn_In << 1;
                  mplier_q <= val2 >> 1;
                  cnt_q    <= '0;
                  state_q  <= MUL_BUSY;
               end
            end
            MUL_BUSY: begin
               if (mplier_q[0]) prod_q <= prod_q + mcand_q;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) state_q <= MUL_DONE;
            end
            default: state_q <= MUL_IDLE;
         endcase
      end
   end

   // Stall is raised combinationally in the accept cycle so the front end
   // holds the MUL in ID/EX; it drops as soon as reset is asserted.
   assign Stall   = !RST && ((state_q == MUL_IDLE && isMul) || state_q == MUL_BUSY);
   assign ALU_Res = (state_q == MUL_DONE) ? prod_q : aluRes;
`else
   assign Stall   = 1'b0;
   assign ALU_Res = aluRes;
`endif

   // Next status value. MUL only updates N and Z, and only when it completes;
   // logical ops keep C and V.
   always_comb begin
      sr_d = sr_q;
      if (S_In && !Stall) begin
`ifdef EXE_MUL_EN
         if (state_q == MUL_DONE) begin
            sr_d[3] = prod_q[31];
            sr_d[2] = (prod_q == 32'b0);
         end else
`endif
         if (!isMul) begin
            sr_d[3] = aluRes[31];
            sr_d[2] = (aluRes == 32'b0);
            if (isArith) begin
               sr_d[1] = sum33[32];
               sr_d[0] = ovf;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) sr_q <= 4'b0000;
      else     sr_q <= sr_d;
   end

   assign SR = sr_q;

endmodule

// File: tb/tb_exe_stage.sv
// Testbench for exe_stage: directed cases followed by randomized instructions.
// The driver issues one instruction per cycle and pushes the expected response
// (from a plain-arithmetic reference model) into a queue; the monitor pops and
// compares on every falling edge.
module tb_exe_stage;

   localparam int MUL_CYCLES = 32;

   logic        CLK = 1'b0;
   logic        RST;
   logic [3:0]  EXE_CMD_In;
   logic        MEM_R_EN_In;
   logic        MEM_W_EN_In;
   logic        B_In;
   logic        S_In;
   logic [31:0] PC_In;
   logic [31:0] Val_Rn_In;
   logic [31:0] Val_Rm_In;
   logic        imm_In;
   logic [11:0] Shift_operand_In;
   logic [23:0] Signed_imm_24_In;
   logic [31:0] ALU_Res;
   logic [31:0] Br_Addr;
   logic        Branch_Taken;
   logic [3:0]  SR;
   logic        Stall;

   always #5 CLK = ~CLK;

   exe_stage dut (
      .CLK              (CLK),
      .RST              (RST),
      .EXE_CMD_In       (EXE_CMD_In),
      .MEM_R_EN_In      (MEM_R_EN_In),
      .MEM_W_EN_In      (MEM_W_EN_In),
      .B_In             (B_In),
      .S_In             (S_In),
      .PC_In            (PC_In),
      .Val_Rn_In        (Val_Rn_In),
      .Val_Rm_In        (Val_Rm_In),
      .imm_In           (imm_In),
      .Shift_operand_In (Shift_operand_In),
      .Signed_imm_24_In (Signed_imm_24_In),
      .ALU_Res          (ALU_Res),
      .Br_Addr          (Br_Addr),
      .Branch_Taken     (Branch_Taken),
      .SR               (SR),
      .Stall            (Stall)
   );

   typedef struct {
      string       name;
      bit          chkAlu;
      logic [31:0] alu;
      logic [31:0] br;
      logic        taken;
      logic [3:0]  sr;
      logic        stall;
   } exp_t;

   exp_t        expQ[$];
   exp_t        mon;
   int          compared   = 0;
   int          mismatched = 0;
   logic [3:0]  mSr        = 4'b0000;

   // Single comparison point; every compare goes through here.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: one expected record per cycle, sampled mid-cycle.
   always @(negedge CLK) begin
      if (expQ.size() > 0) begin
         mon = expQ.pop_front();
         if (mon.chkAlu) checkOutput({mon.name, " alu"}, ALU_Res, mon.alu);
         checkOutput({mon.name, " br"},    Br_Addr, mon.br);
         checkOutput({mon.name, " taken"}, 32'(Branch_Taken), 32'(mon.taken));
         checkOutput({mon.name, " sr"},    32'(SR), 32'(mon.sr));
         checkOutput({mon.name, " stall"}, 32'(Stall), 32'(mon.stall));
      end
   end

   // Reference: Val2 built bit by bit from the shifter-operand rules.
   function automatic logic [31:0] val2Model(input logic immF, input logic memF,
                                             input logic [11:0] so, input logic [31:0] rm);
      logic [31:0] x;
      int n;
      if (immF) begin
         x = {24'h0, so[7:0]};
         n = 2 * int'(so[11:8]);
         for (int k = 0; k < n; k++) x = {x[0], x[31:1]};
      end else if (memF) begin
         x = {20'h0, so};
      end else begin
         x = rm;
         n = int'(so[11:7]);
         for (int k = 0; k < n; k++) begin
            case (so[6:5])
               2'd0:    x = {x[30:0], 1'b0};
               2'd1:    x = {1'b0, x[31:1]};
               2'd2:    x = {x[31], x[31:1]};
               default: x = {x[0], x[31:1]};
            endcase
         end
      end
      return x;
   endfunction

   function automatic logic [31:0] brModel(input logic [31:0] pc, input logic [23:0] off);
      longint o64;
      o64 = $signed(off);
      o64 = o64 * 4;
      return pc + o64[31:0];
   endfunction

   task automatic pushExp(input string name, input bit chk, input logic [31:0] alu, input logic stall);
      exp_t e;
      e.name   = name;
      e.chkAlu = chk;
      e.alu    = alu;
      e.br     = brModel(PC_In, Signed_imm_24_In);
      e.taken  = B_In;
      e.sr     = mSr;
      e.stall  = stall;
      expQ.push_back(e);
   endtask

   task automatic driveZero();
      EXE_CMD_In = 4'h0; MEM_R_EN_In = 1'b0; MEM_W_EN_In = 1'b0; B_In = 1'b0;
      S_In = 1'b0; PC_In = 32'h0; Val_Rn_In = 32'h0; Val_Rm_In = 32'h0;
      imm_In = 1'b0; Shift_operand_In = 12'h0; Signed_imm_24_In = 24'h0;
   endtask

   // Issue one single-cycle instruction and record what it should produce.
   task automatic applyStimulus(input string name, input logic [3:0] cmd,
                                input logic memR, input logic memW, input logic br,
                                input logic s, input logic [31:0] pc,
                                input logic [31:0] rn, input logic [31:0] rm,
                                input logic immF, input logic [11:0] so,
                                input logic [23:0] off);
      logic [31:0] v2, res;
      logic [3:0]  op;
      bit arith, c, v, cin, borrow;
      longint unsigned ua, ub, uu;
      longint sa, sb, ss;
      @(posedge CLK); #1;
      EXE_CMD_In = cmd; MEM_R_EN_In = memR; MEM_W_EN_In = memW; B_In = br;
      S_In = s; PC_In = pc; Val_Rn_In = rn; Val_Rm_In = rm; imm_In = immF;
      Shift_operand_In = so; Signed_imm_24_In = off;

      op = (memR || memW) ? 4'b0010 : cmd;
      v2 = val2Model(immF, memR || memW, so, rm);
      ua = 64'(rn); ub = 64'(v2);
      sa = $signed(rn); sb = $signed(v2);
      cin = mSr[1]; borrow = !cin;
      c = mSr[1]; v = mSr[0]; arith = 0; ss = 0; res = 32'h0;
      case (op)
         4'b0001: res = v2;
         4'b1001: res = ~v2;
         4'b0110: res = rn & v2;
         4'b0111: res = rn | v2;
         4'b1000: res = rn ^ v2;
         4'b0010: begin uu = ua + ub; res = uu[31:0]; c = (uu >= 64'h1_0000_0000); ss = sa + sb; arith = 1; end
         4'b0011: begin uu = ua + ub + 64'(cin); res = uu[31:0]; c = (uu >= 64'h1_0000_0000);
                        ss = sa + sb + longint'(cin); arith = 1; end
         4'b0100: begin res = rn - v2; c = (ua >= ub); ss = sa - sb; arith = 1; end
         4'b0101: begin res = rn - v2 - 32'(borrow); c = (ua >= ub + 64'(borrow));
                        ss = sa - sb - longint'(borrow); arith = 1; end
         default: res = 32'h0;
      endcase
      if (arith) v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);

      pushExp(name, 1'b1, res, 1'b0);
      if (s && op != 4'b1111) begin
         mSr[3] = res[31];
         mSr[2] = (res == 32'h0);
         if (arith) begin mSr[1] = c; mSr[0] = v; end
      end
   endtask

`ifdef EXE_MUL_EN
   // Multiply held in ID/EX for its whole occupancy; abortAt > 0 pulses reset
   // at that stall cycle instead of completing.
   task automatic applyMul(input string name, input logic [31:0] rn, input logic [31:0] rm,
                           input logic s, input int abortAt);
      logic [31:0] prod;
      @(posedge CLK); #1;
      driveZero();
      EXE_CMD_In = 4'b1111; S_In = s; Val_Rn_In = rn; Val_Rm_In = rm;
      prod = rn * rm;
      for (int k = 0; k < MUL_CYCLES; k++) begin
         if (k > 0) begin @(posedge CLK); #1; end
         if (abortAt > 0 && k == abortAt) begin
            RST = 1'b1;
            driveZero();
            pushExp({name, " rst"}, 1'b0, 32'h0, 1'b0);
            @(posedge CLK); #1;
            RST = 1'b0;
            mSr = 4'b0000;
            pushExp({name, " after rst"}, 1'b0, 32'h0, 1'b0);
            return;
         end
         pushExp({name, " busy"}, 1'b0, 32'h0, 1'b1);
      end
      @(posedge CLK); #1;
      pushExp({name, " done"}, 1'b1, prod, 1'b0);
      if (s) begin mSr[3] = prod[31]; mSr[2] = (prod == 32'h0); end
   endtask
`endif

   function automatic logic [31:0] pick32();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h7FFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic printSummary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
   endtask

   initial begin
      logic [3:0] aluOps [9];
      logic [3:0] cmd;
      logic       mr, mw, br;
      int         kind;
      aluOps = '{4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b0100,
                 4'b0101, 4'b0110, 4'b0111, 4'b1000};

      RST = 1'b1;
      driveZero();
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      pushExp("reset", 1'b0, 32'h0, 1'b0);

      applyStimulus("add ovf",  4'b0010, 0, 0, 0, 1, 32'h0, 32'h7FFF_FFFF, 32'h0, 1, 12'h001, 24'h0);
      applyStimulus("sub zero", 4'b0100, 0, 0, 0, 1, 32'h0, 32'h5, 32'h5, 0, 12'h000, 24'h0);
      applyStimulus("adc nos",  4'b0011, 0, 0, 0, 0, 32'h0, 32'h1, 32'h1, 0, 12'h000, 24'h0);
      applyStimulus("imm rot",  4'b0001, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 12'h4FF, 24'h0);
      applyStimulus("asr4",     4'b0001, 0, 0, 0, 0, 32'h0, 32'h0, 32'h8000_0000, 0, 12'h240, 24'h0);
      applyStimulus("ldr",      4'b0000, 1, 0, 0, 0, 32'h0, 32'h100, 32'h0, 0, 12'h004, 24'h0);
      applyStimulus("branch",   4'b0001, 0, 0, 1, 0, 32'h20, 32'h0, 32'h0, 0, 12'h000, 24'hFFFFFE);
      applyStimulus("sbc",      4'b0101, 0, 0, 0, 1, 32'h0, 32'h0, 32'h1, 0, 12'h000, 24'h0);
`ifdef EXE_MUL_EN
      applyMul("mul 7x6", 32'd7, 32'd6, 1'b1, 0);
      applyStimulus("post mul", 4'b0001, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 12'h000, 24'h0);
      applyMul("mul abort", $urandom, $urandom, 1'b1, 10);
`else
      applyStimulus("mul off",  4'b1111, 0, 0, 0, 1, 32'h0, 32'd7, 32'd6, 0, 12'h000, 24'h0);
`endif

      for (int i = 0; i < 300; i++) begin
         kind = $urandom_range(0, 11);
         mr = 1'b0; mw = 1'b0;
         br = ($urandom_range(0, 3) == 0);
         if (kind <= 8) begin
            cmd = aluOps[kind];
         end else if (kind == 9) begin
            cmd = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) mr = 1'b1; else mw = 1'b1;
         end else if (kind == 10) begin
`ifdef EXE_MUL_EN
            cmd = aluOps[$urandom_range(0, 8)];
`else
            cmd = 4'b1111;
`endif
         end else begin
            cmd = aluOps[$urandom_range(0, 8)];
            br  = 1'b1;
         end
         applyStimulus("rand", cmd, mr, mw, br, 1'($urandom_range(0, 1)), $urandom,
                       pick32(), pick32(), 1'($urandom_range(0, 1)),
                       12'($urandom), 24'($urandom));
      end
      applyStimulus("final", 4'b0001, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 12'h000, 24'h0);

      @(negedge CLK); #1;
      if (expQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
      end
      printSummary();
      $finish;
   end

   initial begin
      #500000;
      mismatched++;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      printSummary();
      $finish;
   end

endmodule
